softmax_bwd_stream: RTL and testbench

Synthesizable streaming backward pass for the softmax layer. Per frame it takes the forward probabilities p[i] and the upstream gradient g[i], and produces the score gradient dx[i] = p[i]·(g[i] − Σⱼ p[j]·g[j]). It sits between the loss/gradient path and the score-producing stage, mirroring the forward softmax. The whole datapath is fixed point; no real arithmetic.

---
 rtl/softmax_pkg.sv | 26 ++
 rtl/fx_mul_shift.sv | 28 ++
 rtl/softmax_bwd_stream.sv | 139 +++++++++++++
 tb/tb_softmax_bwd_stream.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared constants, state type and saturation helper
// for the softmax backward streaming datapath.
package softmax_pkg;

  localparam logic [15:0] P_ONE = 16'h8000;
  localparam int          PF    = 15;

  typedef enum logic {
    LOAD,
    DRAIN
  } sm_bwd_state_e;

  function automatic logic signed [63:0] sat_signed(
    input logic signed [63:0] value,
    input int                 width
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/fx_mul_shift.sv
// Signed a times unsigned b, arithmetic shift right by SH (floor),
// then saturate (SAT=1) or sign-truncate (SAT=0) to OW bits.
module fx_mul_shift
  import softmax_pkg::*;
#(
  parameter int AW  = 16,
  parameter int BW  = 16,
  parameter int OW  = 16,
  parameter int SH  = PF,
  parameter bit SAT = 1'b1
) (
  input  logic signed [AW-1:0] a,
  input  logic        [BW-1:0] b,
  output logic signed [OW-1:0] o
);

  localparam int PRW = AW + BW + 1;

  logic signed [PRW-1:0] prod;
  logic signed [PRW-1:0] sh;

  // b is zero-extended so it multiplies as a non-negative value
  assign prod = PRW'(a) * PRW'($signed({1'b0, b}));
  assign sh   = prod >>> SH;

  assign o = OW'(SAT ? sat_signed(64'(sh), OW) : 64'(sh));

endmodule

// File: rtl/softmax_bwd_stream.sv
// Streaming softmax backward: dx[i] = p[i]*(g[i] - sum_j p[j]*g[j]).
// Ports: clk/rst_n, in_* (p,g,last) valid/ready, out_* (dx,last) valid/ready.
module softmax_bwd_stream
  import softmax_pkg::*;
#(
  parameter int LEN = 16,
  parameter int PW  = 16,
  parameter int GW  = 16,
  parameter int GF  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PW-1:0]        in_p,
  input  logic signed [GW-1:0] in_g,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [GW-1:0] out_dx,
  output logic                 out_last
);

  localparam int IW  = $clog2(LEN);
  localparam int NW  = $clog2(LEN + 1);
  localparam int EW  = PW + GW;
  localparam int MW  = PW + GW + 1;
  localparam int ACW = PW + GW + 1 + $clog2(LEN);

  if (PW != 16 || LEN < 2 || GF >= GW) begin : g_param_check
    $error("softmax_bwd_stream: unsupported parameters");
  end

  sm_bwd_state_e state_q, state_d;

  logic [IW-1:0]         wr_idx_q;
  logic [IW-1:0]         rd_idx_q;
  logic [NW-1:0]         n_q;
  logic signed [ACW-1:0] acc_q;
  logic signed [GW:0]    s_q;
  logic [EW-1:0]         buf_q [LEN];

  logic                  in_fire;
  logic                  out_fire;
  logic                  frame_end;
  logic signed [MW-1:0]  mac_prod;
  logic signed [ACW-1:0] acc_next;
  logic [EW-1:0]         rd_entry;
  logic [PW-1:0]         rd_p;
  logic signed [GW-1:0]  rd_g;
  logic signed [GW+1:0]  d;
  logic signed [GW-1:0]  dx;

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign frame_end = in_last | (wr_idx_q == IW'(LEN - 1));

  fx_mul_shift #(
    .AW (GW),
    .BW (PW),
    .OW (MW),
    .SH (0),
    .SAT(1'b0)
  ) u_mac (
    .a(in_g),
    .b(in_p),
    .o(mac_prod)
  );

  assign acc_next = acc_q + ACW'(mac_prod);

  assign rd_entry = buf_q[rd_idx_q];
  assign rd_p     = rd_entry[EW-1:GW];
  assign rd_g     = rd_entry[GW-1:0];
  assign d        = $signed({{2{rd_g[GW-1]}}, rd_g})
                  - $signed({s_q[GW], s_q});

  fx_mul_shift #(
    .AW (GW + 2),
    .BW (PW),
    .OW (GW),
    .SH (PF),
    .SAT(1'b1)
  ) u_dx (
    .a(d),
    .b(rd_p),
    .o(dx)
  );

  // gated so the idle output is a clean zero
  assign out_last = out_valid & (NW'(rd_idx_q) == n_q - NW'(1));
  assign out_dx   = out_valid ? dx : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (in_fire && frame_end) state_d = DRAIN;
      DRAIN:   if (out_fire && out_last) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      s_q      <= '0;
    end else begin
      if (in_fire) begin
        if (frame_end) begin
          acc_q    <= '0;
          wr_idx_q <= '0;
          n_q      <= NW'(wr_idx_q) + NW'(1);
          s_q      <= (GW + 1)'(acc_next >>> PF);
        end else begin
          acc_q    <= acc_next;
          wr_idx_q <= wr_idx_q + IW'(1);
        end
      end
      if (out_fire) begin
        rd_idx_q <= out_last ? '0 : rd_idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) buf_q[wr_idx_q] <= {in_p, in_g};
  end

endmodule

// File: tb/tb_softmax_bwd_stream.sv
// Directed self-checking bench for softmax_bwd_stream, LEN=4.
// Inputs driven 1 time unit after posedge; outputs sampled there too.
module tb_softmax_bwd_stream;
  import softmax_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_p;
  logic [15:0] in_g;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_dx;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  logic [15:0] rx_dx[$];
  logic        rx_last[$];

  always #5 clk = ~clk;

  softmax_bwd_stream #(
    .LEN(4),
    .PW (16),
    .GW (16),
    .GF (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_p     (in_p),
    .in_g     (in_g),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_dx   (out_dx),
    .out_last (out_last)
  );

  task automatic drive(input logic [15:0] p[4], input logic [15:0] g[4],
                       input int n, input bit mark);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_p     = p[i];
      in_g     = g[i];
      in_last  = mark && (i == n - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_p     = '0;
    in_g     = '0;
  endtask

  task automatic collect(output bit tmo, output bit rdy_hi);
    int cyc = 0;
    bit done = 1'b0;
    rx_dx.delete();
    rx_last.delete();
    tmo = 1'b0;
    rdy_hi = 1'b0;
    out_ready = 1'b1;
    while (!done) begin
      if (out_valid && in_ready) rdy_hi = 1'b1;
      if (out_valid) begin
        rx_dx.push_back(out_dx);
        rx_last.push_back(out_last);
        done = out_last;
      end
      @(posedge clk); #1;
      cyc++;
      if (!done && cyc >= 40) begin
        tmo = 1'b1;
        done = 1'b1;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_last !== 1'b0) begin
      errors++; $display("FAIL reset_out_last got %b want 0", out_last);
    end
    checks++;
    if (out_dx !== 16'h0000) begin
      errors++; $display("FAIL reset_out_dx got %h want 0000", out_dx);
    end
  endtask

  task automatic test_basic;
    logic [15:0] exp[4];
    bit tmo, rh;
    exp = '{16'h0080, 16'hFF80, 16'h0000, 16'h0000};
    drive('{16'h4000, 16'h4000, 16'h0000, 16'h0000},
          '{16'h0100, 16'hFF00, 16'h0000, 16'h0000}, 4, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL basic_latency out_valid got %b want 1", out_valid);
    end
    collect(tmo, rh);
    checks++;
    if (tmo || rx_dx.size() !== 4) begin
      errors++; $display("FAIL basic_count got %0d want 4", rx_dx.size());
    end
    for (int i = 0; i < rx_dx.size() && i < 4; i++) begin
      checks++;
      if (rx_dx[i] !== exp[i]) begin
        errors++; $display("FAIL basic_dx[%0d] got %h want %h", i, rx_dx[i], exp[i]);
      end
      checks++;
      if (rx_last[i] !== (i == 3)) begin
        errors++; $display("FAIL basic_last[%0d] got %b want %b", i, rx_last[i], i == 3);
      end
    end
  endtask

  task automatic test_mean_shift;
    logic [15:0] exp[4];
    bit tmo, rh;
    exp = '{16'h00C0, 16'hFFC0, 16'hFFC0, 16'hFFC0};
    drive('{16'h2000, 16'h2000, 16'h2000, 16'h2000},
          '{16'h0400, 16'h0000, 16'h0000, 16'h0000}, 4, 1'b0);
    collect(tmo, rh);
    checks++;
    if (tmo || rx_dx.size() !== 4) begin
      errors++; $display("FAIL shift_count got %0d want 4", rx_dx.size());
    end
    for (int i = 0; i < rx_dx.size() && i < 4; i++) begin
      checks++;
      if (rx_dx[i] !== exp[i]) begin
        errors++; $display("FAIL shift_dx[%0d] got %h want %h", i, rx_dx[i], exp[i]);
      end
    end
    checks++;
    if (rx_last.size() == 4 && rx_last[3] !== 1'b1) begin
      errors++; $display("FAIL shift_last got %b want 1", rx_last[3]);
    end
  endtask

  task automatic test_one_hot;
    bit tmo, rh;
    drive('{P_ONE, 16'h0000, 16'h0000, 16'h0000},
          '{16'h0300, 16'h0100, 16'hFF00, 16'h0000}, 4, 1'b1);
    collect(tmo, rh);
    checks++;
    if (tmo || rx_dx.size() !== 4) begin
      errors++; $display("FAIL onehot_count got %0d want 4", rx_dx.size());
    end
    for (int i = 0; i < rx_dx.size() && i < 4; i++) begin
      checks++;
      if (rx_dx[i] !== 16'h0000) begin
        errors++; $display("FAIL onehot_dx[%0d] got %h want 0000", i, rx_dx[i]);
      end
    end
  endtask

  task automatic test_short_frame;
    bit tmo, rh;
    drive('{16'h4000, 16'h4000, 16'h0000, 16'h0000},
          '{16'h0100, 16'hFF00, 16'h0000, 16'h0000}, 2, 1'b1);
    collect(tmo, rh);
    checks++;
    if (tmo || rx_dx.size() !== 2) begin
      errors++; $display("FAIL short_count got %0d want 2", rx_dx.size());
    end
    if (rx_dx.size() == 2) begin
      checks++;
      if (rx_dx[0] !== 16'h0080 || rx_dx[1] !== 16'hFF80) begin
        errors++;
        $display("FAIL short_dx got %h %h want 0080 ff80", rx_dx[0], rx_dx[1]);
      end
      checks++;
      if (rx_last[0] !== 1'b0 || rx_last[1] !== 1'b1) begin
        errors++;
        $display("FAIL short_last got %b%b want 01", rx_last[0], rx_last[1]);
      end
    end
    checks++;
    if (rh !== 1'b0) begin
      errors++; $display("FAIL short_in_ready_drain got %b want 0", rh);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL short_in_ready_after got %b want 1", in_ready);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] exp[4];
    logic [15:0] held_dx;
    logic        held_last;
    bit          stalled = 1'b0;
    bit          done = 1'b0;
    int          cyc = 0;
    int          bad = 0;
    exp = '{16'h00C0, 16'hFFC0, 16'hFFC0, 16'hFFC0};
    drive('{16'h2000, 16'h2000, 16'h2000, 16'h2000},
          '{16'h0400, 16'h0000, 16'h0000, 16'h0000}, 4, 1'b1);
    rx_dx.delete();
    rx_last.delete();
    while (!done && cyc < 40) begin
      out_ready = cyc[0];
      if (stalled && (out_valid !== 1'b1 || out_dx !== held_dx
                      || out_last !== held_last)) bad++;
      stalled = out_valid && !out_ready;
      held_dx = out_dx;
      held_last = out_last;
      if (out_valid && out_ready) begin
        rx_dx.push_back(out_dx);
        rx_last.push_back(out_last);
        done = out_last;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL bp_stable got %0d unstable stalls want 0", bad);
    end
    checks++;
    if (!done || rx_dx.size() !== 4) begin
      errors++; $display("FAIL bp_count got %0d want 4", rx_dx.size());
    end
    for (int i = 0; i < rx_dx.size() && i < 4; i++) begin
      checks++;
      if (rx_dx[i] !== exp[i] || rx_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL bp_dx[%0d] got %h/%b want %h/%b",
                 i, rx_dx[i], rx_last[i], exp[i], i == 3);
      end
    end
  endtask

  task automatic test_reset_mid_drain;
    logic [15:0] exp[4];
    bit tmo, rh;
    exp = '{16'h0080, 16'hFF80, 16'h0000, 16'h0000};
    drive('{16'h4000, 16'h4000, 16'h0000, 16'h0000},
          '{16'h0100, 16'hFF00, 16'h0000, 16'h0000}, 4, 1'b1);
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_dx !== 16'h0080) begin
      errors++; $display("FAIL rst_first_dx got %b/%h want 1/0080", out_valid, out_dx);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive('{16'h2000, 16'h2000, 16'h2000, 16'h2000},
          '{16'h0400, 16'h0000, 16'h0000, 16'h0000}, 2, 1'b0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive('{16'h4000, 16'h4000, 16'h0000, 16'h0000},
          '{16'h0100, 16'hFF00, 16'h0000, 16'h0000}, 4, 1'b1);
    collect(tmo, rh);
    checks++;
    if (tmo || rx_dx.size() !== 4) begin
      errors++; $display("FAIL rst_count got %0d want 4", rx_dx.size());
    end
    for (int i = 0; i < rx_dx.size() && i < 4; i++) begin
      checks++;
      if (rx_dx[i] !== exp[i]) begin
        errors++; $display("FAIL rst_dx[%0d] got %h want %h", i, rx_dx[i], exp[i]);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_p      = '0;
    in_g      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic;
    test_mean_shift;
    test_one_hot;
    test_short_frame;
    test_backpressure;
    test_reset_mid_drain;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
